// File: rtl/pool_2x2_seq_if.sv
// pool_2x2_seq_if
// Bundles the sequencer's stream input, its pool-unit control output and its
// frame status toward the layer controller.
//   start, conv_vld, conv_in : frame arm pulse and raster conv stream (into seq)
//   in_vld, sel, conv        : issue to the 2x2 max-pool datapath (from seq)
//   pool_vld, pool_row       : pooled row complete this cycle, and its index
//   busy, frame_done         : frame status
//   err                      : sticky stray-input flag (only with POOL_SEQ_CHK_EN)
// Modports: slave = sequencer side, master = driver/consumer side.
interface pool_2x2_seq_if #(
  parameter int RW = 2
);
  logic          start;
  logic          conv_vld;
  logic [7:0]    conv_in;
  logic          in_vld;
  logic [2:0]    sel;
  logic [7:0]    conv;
  logic          pool_vld;
  logic [RW-1:0] pool_row;
  logic          busy;
  logic          frame_done;
`ifdef POOL_SEQ_CHK_EN
  logic          err;

  modport slave (
    input  start, conv_vld, conv_in,
    output in_vld, sel, conv, pool_vld, pool_row, busy, frame_done, err
  );
  modport master (
    output start, conv_vld, conv_in,
    input  in_vld, sel, conv, pool_vld, pool_row, busy, frame_done, err
  );
`else
  modport slave (
    input  start, conv_vld, conv_in,
    output in_vld, sel, conv, pool_vld, pool_row, busy, frame_done
  );
  modport master (
    output start, conv_vld, conv_in,
    input  in_vld, sel, conv, pool_vld, pool_row, busy, frame_done
  );
`endif
endinterface

// File: rtl/pool_2x2_seq.sv
// pool_2x2_seq
// Control sequencer for a 3-slot 2x2 max-pool unit. Accepts a raster-ordered
// stream of signed 8-bit conv results, registers each one and issues it with
// the slot/op code that folds it into its 2x2 window. Flags the cycle in which
// a whole pooled row is valid at the pool output, and reports frame status.
// Ports:
//   i_clk : system clock
//   i_rst : synchronous active-high reset
//   bus   : pool_2x2_seq_if.slave (stream in, pool control out, status)
// Parameters: MAP_W (2, 4 or 6), MAP_H (even, >= 2).
// Optional build macro POOL_SEQ_CHK_EN adds the sticky err output.
//
// state  | meaning
// IDLE   | waiting for start; stream input ignored
// RUN    | accepting pixels on conv_vld, busy=1
// DONE   | last pixel accepted; one cycle before returning to IDLE
module pool_2x2_seq #(
  parameter int MAP_W = 6,
  parameter int MAP_H = 6
) (
  input logic          i_clk,
  input logic          i_rst,
  pool_2x2_seq_if.slave bus
);
  localparam int CW  = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int RHW = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int RW  = (MAP_H / 2 > 1) ? $clog2(MAP_H / 2) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [CW-1:0]  r_col;
  logic [RHW-1:0] r_row;
  logic           r_in_vld, r_pool_vld, r_frame_done;
  logic [2:0]     r_sel;
  logic [7:0]     r_conv;
  logic [RW-1:0]  r_pool_row;

  logic           w_accept, w_last, w_col_last, w_row_last, w_upd;
  logic [2:0]     w_d, w_sel;

  assign w_col_last = (r_col == CW'(MAP_W - 1));
  assign w_row_last = (r_row == RHW'(MAP_H - 1));

  // Even code loads the slot on the window's first sample (even row, even
  // col); every other sample of the window is a max-update (odd code).
  assign w_upd = r_row[0] | r_col[0];
  assign w_d   = 3'(r_col >> 1);
  assign w_sel = (w_d << 1) | {2'b00, w_upd};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_RUN;
      S_RUN: begin
        w_accept = bus.conv_vld;
        w_last   = bus.conv_vld & w_col_last & w_row_last;
        if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_in_vld     <= 1'b0;
      r_sel        <= 3'd0;
      r_conv       <= 8'd0;
      r_pool_vld   <= 1'b0;
      r_pool_row   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_in_vld     <= w_accept;
      // The pool unit's last slot is combinational on its input, so the whole
      // pooled row is final in the same cycle as the issue of the row's last pixel.
      r_pool_vld   <= w_accept & r_row[0] & w_col_last;
      r_frame_done <= w_last;
      if (w_accept) begin
        r_conv <= bus.conv_in;
        r_sel  <= w_sel;
        if (r_row[0] && w_col_last) r_pool_row <= RW'(r_row >> 1);
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + RHW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end else if (r_state == S_IDLE && bus.start) begin
        r_col <= '0;
        r_row <= '0;
      end
    end
  end

`ifdef POOL_SEQ_CHK_EN
  logic r_err;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_err <= 1'b0;
    else if ((bus.conv_vld && r_state != S_RUN) || (bus.start && r_state == S_RUN))
      r_err <= 1'b1;
  end
  assign bus.err = r_err;
`endif

  assign bus.in_vld     = r_in_vld;
  assign bus.sel        = r_sel;
  assign bus.conv       = r_conv;
  assign bus.pool_vld   = r_pool_vld;
  assign bus.pool_row   = r_pool_row;
  assign bus.busy       = (r_state == S_RUN);
  assign bus.frame_done = r_frame_done;
endmodule
